fan_cmd_sequencer: RTL and testbench
====================================

Name: fan_cmd_sequencer

Overview:
- Sits directly upstream of the fan-remote packet generator.
- Accepts speed/light requests over a valid/ready handshake, then drives the generator's cmd bus and one-cycle start strobe.
- Each accepted command goes out as REPEAT_COUNT packets. Each packet is followed by a fixed inter-packet gap, as the fan receiver requires.
- The generator has no done output, so packet timing comes from an internal down-counter clocked by ref_clk.

Parameters:
- PACKET_CYCLES, 79872, ref_clk cycles one packet occupies (13 symbols x 3 PWM phases x 2048); must be >= 2.
- GAP_CYCLES, 16384, ref_clk cycles of idle line after each packet; must be >= 1.
- REPEAT_COUNT, 4, packets sent per accepted command; must be >= 1.
- TIMER_WIDTH, 18, width of the period timer; must hold PACKET_CYCLES+GAP_CYCLES-1.
- CMD_MAX, 4, highest valid command code.

Ports:
- ref_clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high.
- req_valid, input, 1, request present.
- req_cmd, input, 3, requested command code.
- req_ready, output, 1, sequencer can accept a request this cycle.
- gen_cmd, output, 3, command to the generator; held stable for the whole burst.
- gen_start, output, 1, one-cycle start strobe to the generator.
- busy, output, 1, burst in progress.
- done, output, 1, one-cycle pulse when a burst completes.
- cmd_err, output, 1, one-cycle pulse when a request with req_cmd > CMD_MAX is accepted.

Behaviour:
- Interface: one clock (ref_clk); reset is synchronous and active-high.
- Reset values, state on the first edge with reset=1:
  - state=IDLE, gen_start=0, gen_cmd=0, busy=0, done=0, cmd_err=0, timer=0, repeat counter=0.
  - req_ready=0 while reset is high.
- States:
  - IDLE: req_ready=1.
    - Valid command accepted (req_valid&&req_ready, req_cmd<=CMD_MAX): latch gen_cmd=req_cmd; next state START.
    - Invalid command accepted: cmd_err=1 for the next cycle only; stay IDLE; gen_cmd unchanged; no packet sent.
  - START: gen_start=1 for exactly this one cycle.
    - Load timer=PACKET_CYCLES+GAP_CYCLES-1.
    - Increment the repeat counter.
    - Next state WAIT.
  - WAIT: timer decrements once per cycle.
    - On the cycle timer==1: if repeat counter==REPEAT_COUNT, go to IDLE, clear the counter, and pulse done=1 in the first IDLE cycle. Otherwise go to START.
- Timing:
  - Rising edge to rising edge of consecutive gen_start pulses within a burst is exactly PACKET_CYCLES+GAP_CYCLES cycles.
  - First gen_start occurs 1 cycle after the accepting edge.
  - req_ready returns high exactly PACKET_CYCLES+GAP_CYCLES cycles after the last gen_start rise.
- busy=1 in START and WAIT, 0 in IDLE.
- gen_cmd changes only in IDLE on acceptance, never mid-burst.
- req_ready=0 in START and WAIT. Requests presented then are not consumed; the requester must hold them.
- Reset mid-burst: immediate return to IDLE next edge; gen_start never asserted during or on the edge after reset; no done pulse.
- Timer arithmetic is unsigned TIMER_WIDTH; no wrap occurs within a period.

Optional Feature:
- Macro: FAN_CMD_PENDING_EN.
- When defined:
  - One-entry pending register. During START/WAIT, req_ready = !pending_valid.
  - An accepted valid request is stored. An invalid one pulses cmd_err and is dropped.
  - At burst end with pending_valid=1: skip IDLE, load gen_cmd from pending, clear pending, enter START directly (first pending gen_start PACKET_CYCLES+GAP_CYCLES after the previous one).
  - done still pulses on that transition cycle; busy stays 1.
  - Reset clears pending.
- When undefined: no pending storage; req_ready high only in IDLE, as above.

Test Plan (PACKET_CYCLES=10, GAP_CYCLES=5, REPEAT_COUNT=3):
- Reset held 3 cycles with req_valid=1, req_cmd=2 -> req_ready=0, gen_start=0, busy=0 throughout; nothing accepted.
- After reset, req_cmd=2 pulsed with valid in IDLE -> gen_start high for 1 cycle at t+1, t+16, t+31; gen_cmd=2 constant; done pulse at t+46; req_ready high from t+46.
- req_cmd=6 accepted -> cmd_err pulse 1 cycle later, no gen_start for 50 cycles, state remains IDLE.
- Request cmd=1 held valid during an active burst (macro off) -> req_ready=0 until burst ends; accepted in the first IDLE cycle; its first gen_start one cycle later.
- Reset asserted at the 2nd gen_start+4 -> next cycle busy=0, req_ready=1 after reset drops, no further gen_start, no done.
- FAN_CMD_PENDING_EN: cmd=0 burst, then cmd=4 accepted mid-burst -> a second request is blocked (req_ready=0); 4th gen_start has gen_cmd=4, spaced 15 cycles after the 3rd; busy stays 1 across the boundary.

Source files
------------

// File: rtl/fan_cmd_sequencer.sv
// Fan command sequencer: turns each accepted speed/light command into a timed burst of generator start strobes.
// Latency: first gen_start 1 cycle after acceptance; start strobes PACKET_CYCLES+GAP_CYCLES apart; done 1 cycle after the last period.
// Backpressure: req_ready low while a burst runs (or while the pending slot is full when FAN_CMD_PENDING_EN is defined).
// Optional feature macro: FAN_CMD_PENDING_EN adds a one-entry pending command register.
module fan_cmd_sequencer #(
  parameter int PACKET_CYCLES = 79872,
  parameter int GAP_CYCLES    = 16384,
  parameter int REPEAT_COUNT  = 4,
  parameter int TIMER_WIDTH   = 18,
  parameter int CMD_MAX       = 4
) (
  input  logic       ref_clk,
  input  logic       reset,
  input  logic       req_valid,
  input  logic [2:0] req_cmd,
  output logic       req_ready,
  output logic [2:0] gen_cmd,
  output logic       gen_start,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  localparam int CNT_W = $clog2(REPEAT_COUNT + 1);
  localparam logic [TIMER_WIDTH-1:0] PERIOD_LOAD = TIMER_WIDTH'(PACKET_CYCLES + GAP_CYCLES - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);
  localparam logic [CNT_W-1:0]       REPEAT_LAST = CNT_W'(REPEAT_COUNT);
  localparam logic [2:0]             CMD_LIMIT   = 3'(CMD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                 state, state_nxt;
  logic [TIMER_WIDTH-1:0] timer, timer_nxt;
  logic [CNT_W-1:0]       rep_cnt, rep_cnt_nxt;
  logic [2:0]             gen_cmd_nxt;
  logic                   done_nxt;
  logic                   cmd_err_nxt;
  logic                   accept;
  logic                   cmd_ok;

`ifdef FAN_CMD_PENDING_EN
  logic                   pend_vld, pend_vld_nxt;
  logic [2:0]             pend_cmd, pend_cmd_nxt;
`endif

  assign cmd_ok = (req_cmd <= CMD_LIMIT);
  assign accept = req_valid && req_ready;

  // Handshake and status outputs; gated by reset so nothing leaks out while reset is held.
  always_comb begin
    req_ready = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        req_ready = 1'b1;
      end else begin
`ifdef FAN_CMD_PENDING_EN
        req_ready = !pend_vld;
`else
        req_ready = 1'b0;
`endif
      end
    end
  end

  assign gen_start = (state == START) && !reset;
  assign busy      = (state != IDLE) && !reset;

  // Next-state, period timer, repeat counter and command latch.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    rep_cnt_nxt = rep_cnt;
    gen_cmd_nxt = gen_cmd;
    done_nxt    = 1'b0;
    // Out-of-range commands are consumed and flagged, never executed.
    cmd_err_nxt = accept && !cmd_ok;
`ifdef FAN_CMD_PENDING_EN
    pend_vld_nxt = pend_vld;
    pend_cmd_nxt = pend_cmd;
    // Requests arriving mid-burst park in the pending slot.
    if ((state != IDLE) && accept && cmd_ok) begin
      pend_vld_nxt = 1'b1;
      pend_cmd_nxt = req_cmd;
    end
`endif
    unique case (state)
      IDLE: begin
        if (accept && cmd_ok) begin
          gen_cmd_nxt = req_cmd;
          state_nxt   = START;
        end
      end
      START: begin
        timer_nxt   = PERIOD_LOAD;
        rep_cnt_nxt = rep_cnt + CNT_W'(1);
        state_nxt   = WAIT;
      end
      WAIT: begin
        timer_nxt = timer - TIMER_ONE;
        if (timer == TIMER_ONE) begin
          if (rep_cnt == REPEAT_LAST) begin
            rep_cnt_nxt = '0;
            done_nxt    = 1'b1;
            state_nxt   = IDLE;
`ifdef FAN_CMD_PENDING_EN
            // Chain straight into the next burst; a request taken on this very
            // cycle (slot empty) is launched directly instead of being parked.
            if (pend_vld) begin
              gen_cmd_nxt  = pend_cmd;
              pend_vld_nxt = 1'b0;
              state_nxt    = START;
            end else if (accept && cmd_ok) begin
              gen_cmd_nxt  = req_cmd;
              pend_vld_nxt = 1'b0;
              state_nxt    = START;
            end
`endif
          end else begin
            state_nxt = START;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge ref_clk) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      rep_cnt <= '0;
      gen_cmd <= '0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
`ifdef FAN_CMD_PENDING_EN
      pend_vld <= 1'b0;
      pend_cmd <= '0;
`endif
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      rep_cnt <= rep_cnt_nxt;
      gen_cmd <= gen_cmd_nxt;
      done    <= done_nxt;
      cmd_err <= cmd_err_nxt;
`ifdef FAN_CMD_PENDING_EN
      pend_vld <= pend_vld_nxt;
      pend_cmd <= pend_cmd_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fan_cmd_sequencer.sv
// Bench for fan_cmd_sequencer with short timing parameters.
// Reference model tracks bursts as start times and computes outputs from cycle offsets.
// Directed phases from the test plan followed by a randomized request/reset phase.
module tb_fan_cmd_sequencer;

  localparam int P   = 10;
  localparam int G   = 5;
  localparam int R   = 3;
  localparam int PER = P + G;
  localparam int BURST = R * PER;
`ifdef FAN_CMD_PENDING_EN
  localparam bit PEND = 1'b1;
`else
  localparam bit PEND = 1'b0;
`endif

  logic       ref_clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [2:0] req_cmd = 3'd0;
  logic       req_ready;
  logic [2:0] gen_cmd;
  logic       gen_start;
  logic       busy;
  logic       done;
  logic       cmd_err;

  fan_cmd_sequencer #(
    .PACKET_CYCLES(P),
    .GAP_CYCLES   (G),
    .REPEAT_COUNT (R),
    .TIMER_WIDTH  (8),
    .CMD_MAX      (4)
  ) dut (
    .ref_clk  (ref_clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_cmd  (req_cmd),
    .req_ready(req_ready),
    .gen_cmd  (gen_cmd),
    .gen_start(gen_start),
    .busy     (busy),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  always #5 ref_clk = ~ref_clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: a burst is described by the cycle of its first start strobe.
  int         cyc = 0;
  bit         m_act = 1'b0;
  int         m_base = 0;
  logic [2:0] m_cmd = 3'd0;
  int         m_done_at = -1;
  int         m_err_at = -1;
  bit         m_pv = 1'b0;
  logic [2:0] m_pcmd = 3'd0;
  bit         m_acc;
  bit         regs_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs, advance the model past the edge.
  task automatic step(input bit rst, input bit vld, input logic [2:0] cmd);
    int  off;
    bit  e_ready, e_start, e_busy, last;
    @(negedge ref_clk);
    reset = rst;
    req_valid = vld;
    req_cmd = cmd;
    #1;
    off = cyc - m_base;
    e_busy  = !rst && m_act;
    e_start = !rst && m_act && (off % PER == 0);
    e_ready = !rst && (!m_act || (PEND && !m_pv));
    check("req_ready", 32'(req_ready), 32'(e_ready));
    check("gen_start", 32'(gen_start), 32'(e_start));
    check("busy", 32'(busy), 32'(e_busy));
    if (regs_known) begin
      check("done", 32'(done), 32'(cyc == m_done_at));
      check("cmd_err", 32'(cmd_err), 32'(cyc == m_err_at));
      check("gen_cmd", 32'(gen_cmd), 32'(m_cmd));
    end
    m_acc = vld && e_ready;
    if (rst) begin
      m_act = 1'b0;
      m_cmd = 3'd0;
      m_pv = 1'b0;
      m_done_at = -1;
      m_err_at = -1;
      regs_known = 1'b1;
    end else begin
      last = m_act && (off == BURST - 1);
      if (m_acc && cmd > 3'd4) m_err_at = cyc + 1;
      if (!m_act) begin
        if (m_acc && cmd <= 3'd4) begin
          m_act = 1'b1;
          m_base = cyc + 1;
          m_cmd = cmd;
        end
      end else if (last) begin
        m_done_at = cyc + 1;
        if (m_pv) begin
          m_base = cyc + 1;
          m_cmd = m_pcmd;
          m_pv = 1'b0;
        end else if (m_acc && cmd <= 3'd4) begin
          m_base = cyc + 1;
          m_cmd = cmd;
        end else begin
          m_act = 1'b0;
        end
      end else if (m_acc && cmd <= 3'd4) begin
        m_pv = 1'b1;
        m_pcmd = cmd;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0);
  endtask

  initial begin
    bit got;
    // Reset held with a request present: nothing may be accepted.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd2);
    idle(2);
    // Single command 2: three strobes 15 apart, done, ready again.
    step(1'b0, 1'b1, 3'd2);
    idle(55);
    // Out-of-range command: error pulse, no burst.
    step(1'b0, 1'b1, 3'd6);
    idle(50);
    // Command 1 held valid while a burst runs.
    step(1'b0, 1'b1, 3'd0);
    idle(5);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      step(1'b0, 1'b1, 3'd1);
      got = m_acc;
    end
    check("held_req_accepted", 32'(got), 32'd1);
    // Second request during the follow-on burst (blocked or pended).
    idle(3);
    step(1'b0, 1'b1, 3'd4);
    step(1'b0, 1'b1, 3'd3);
    idle(110);
    // Reset four cycles after the second start strobe.
    step(1'b0, 1'b1, 3'd3);
    idle(19);
    step(1'b1, 1'b0, 3'd0);
    idle(50);
    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 400) == 0, ($urandom % 6) == 0, 3'($urandom % 8));
    end
    idle(60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
